deci_engine: RTL and testbench
==============================

# deci_engine

Multi-mode sample decimator between the AD capture front end and the waveform RAM writer. Accepts one ADC sample per qualified clock and emits one output per window of N accepted samples. Output modes:
- plain sampling;
- peak detect (max/min envelope, so glitches survive heavy decimation);
- box averaging (noise reduction).

Rate and mode are runtime inputs. Both are latched per window so that changes never corrupt a window in progress.

## Interface
Parameters:
- DW, 8, ADC sample width
- RW, 10, width of the decimation-rate input

Ports:
- ad_clk  in  1  sample clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- ad_valid  in  1  sample qualifier; tie high to accept every clock
- ad_data  in  DW  unsigned ADC sample
- deci_en  in  1  decimation enable
- deci_rate  in  RW  window length N; 0 and 1 both mean N=1
- deci_mode  in  2  0 = sample, 1 = peak, 2 = average, 3 = treated as sample
- deci_valid  out  1  one-cycle output strobe
- deci_data  out  DW  decimated sample (mode-dependent)
- deci_max  out  DW  window maximum (peak mode)
- deci_min  out  DW  window minimum (peak mode)

## Operation
- Accepted sample: a clock with ad_valid=1 and deci_en=1.
- Window state: a sample counter cnt[RW-1:0], an accumulator acc[DW+RW-1:0], and running max/min registers.

First accepted sample of a window (cnt=0):
- latch N_l = max(deci_rate, 1) and mode_l;
- compute shift k = floor(log2(N_l)) by priority encode;
- load acc = ad_data, max = ad_data, min = ad_data.

Later samples:
- acc += ad_data;
- max/min updated with unsigned compares;
- cnt increments.

The sample that makes cnt reach N_l−1 is the last one in the window. On that sample:
- cnt returns to 0;
- the result is registered;
- deci_valid=1 on the next clock.

Results by mode_l:
- Sample mode: deci_data = the last sample of the window; deci_max and deci_min also carry that sample.
- Peak mode: deci_max and deci_min = window extremes including the last sample; deci_data = deci_max.
- Average mode: deci_data = (acc including the last sample) >> k, truncated to DW bits.
  - Exact mean when N_l is a power of two.
  - For other N_l, the value is sum >> floor(log2 N) and is saturated to 2^DW−1. This is defined behaviour, not an error.
  - deci_max/deci_min still track the window extremes.

Other rules:
- deci_rate/deci_mode changes mid-window: ignored until the next window start.
- deci_en=0: cnt, acc, max and min return to their window-start state on the next clock. deci_valid is forced to 0; a pulse is never emitted for a partial window. Output data registers hold their last values.
- ad_valid=0 gaps: window state is frozen; the gaps do not count toward N.
- Accumulator width DW+RW: no overflow for any N ≤ 2^RW−1.

## Timing
- Latency: deci_valid asserts exactly 1 ad_clk after the clock that accepted the last sample of the window. deci_data, deci_max and deci_min are valid in the same cycle and hold until the next pulse.
- N_l=1: every accepted sample yields a pulse 1 cycle later. Back-to-back pulses are allowed at the full clock rate.
- Minimum spacing between pulses is N_l accepted samples. There is no backpressure, so the consumer must take each pulse.
- Reset:
  - rst=1 at a clock edge clears cnt, acc, max and min;
  - outputs reset to deci_valid=0, deci_data=0, deci_max=0, deci_min=0;
  - N_l=1, mode_l=0;
  - reset mid-window discards the partial window without emitting a pulse.
- rst has priority over deci_en, which has priority over ad_valid.

## Configuration
Macro: DECI_PEAK_EN.
- Defined: peak mode is implemented as described, including the max/min registers and comparators.
- Undefined:
  - the max/min registers and comparators are not synthesised;
  - deci_mode=1 behaves as sample mode;
  - deci_max and deci_min are driven from the deci_data register;
  - average and sample modes are unchanged.

## Test plan
- Sample mode, N=4, ad_valid=1, ad_data ramp 0,1,2,… -> deci_valid pulses every 4 clocks with deci_data 3, 7, 11; first pulse one clock after the sample 3 is accepted.
- Peak mode, N=5, data 10,200,3,50,60 repeated -> deci_max=200, deci_min=3, deci_data=200 each window. Without DECI_PEAK_EN -> deci_data=60 and deci_max=deci_min=60.
- Average mode, N=8, data 0..7 -> deci_data=3 (28>>3). N=6 with all samples 255 -> sum 1530>>2 = 382, saturated to deci_data=255.
- Change deci_rate from 4 to 2 after the 2nd sample of a window, ramp data -> current window still closes on its 4th sample (deci_data=3); subsequent pulses every 2 samples (deci_data 5, 7).
- ad_valid toggling 1,0 with N=3 -> a pulse every 6 clocks; data equals every 3rd valid sample.
- deci_en dropped mid-window, then rst asserted mid-window in a separate run -> no deci_valid pulse for the partial window. The next window counts a full N samples from re-enable/reset release. After reset all outputs are 0.

Source files
------------

// File: rtl/deci_engine_if.sv
// Sample-in / decimated-result-out bundle for deci_engine.
interface deci_engine_if #(
  parameter int DW = 8,
  parameter int RW = 10
);
  logic          ad_valid;
  logic [DW-1:0] ad_data;
  logic          deci_en;
  logic [RW-1:0] deci_rate;
  logic [1:0]    deci_mode;
  logic          deci_valid;
  logic [DW-1:0] deci_data;
  logic [DW-1:0] deci_max;
  logic [DW-1:0] deci_min;

  modport master (
    output ad_valid, ad_data, deci_en, deci_rate, deci_mode,
    input  deci_valid, deci_data, deci_max, deci_min
  );

  modport slave (
    input  ad_valid, ad_data, deci_en, deci_rate, deci_mode,
    output deci_valid, deci_data, deci_max, deci_min
  );
endinterface

// File: rtl/deci_engine.sv
// Multi-mode decimator: sample / peak / box-average over windows of N accepted samples.
// Optional feature macro DECI_PEAK_EN adds the max/min envelope registers and peak mode.
module deci_engine #(
  parameter int DW = 8,
  parameter int RW = 10
) (
  input logic           ad_clk,
  input logic           rst,
  deci_engine_if.slave  bus
);
  localparam int AW = DW + RW;
  localparam int KW = $clog2(RW + 1);
  localparam logic [1:0] MODE_PEAK = 2'd1;
  localparam logic [1:0] MODE_AVG  = 2'd2;

  // Index of the highest set bit; n is never zero here.
  function automatic logic [KW-1:0] flog2(input logic [RW-1:0] n);
    flog2 = '0;
    for (int i = 0; i < RW; i++) begin
      if (n[i]) flog2 = KW'(i);
    end
  endfunction

  logic [RW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [1:0]    mode_q, mode_d;
  logic [KW-1:0] k_q, k_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  logic          first;
  logic          last;
  logic [RW-1:0] rate_in;
  logic [RW-1:0] n_cur;
  logic [1:0]    mode_cur;
  logic [KW-1:0] k_cur;
  logic [AW-1:0] acc_new;
  logic [AW-1:0] shifted;
  logic [DW-1:0] avg;

`ifdef DECI_PEAK_EN
  logic [DW-1:0] max_q, max_d, min_q, min_d;
  logic [DW-1:0] omax_q, omax_d, omin_q, omin_d;
  logic [DW-1:0] max_new, min_new;
`endif

  always_comb begin
    first    = (cnt_q == '0);
    rate_in  = (bus.deci_rate == '0) ? RW'(1) : bus.deci_rate;
    n_cur    = first ? rate_in : rate_q;
    mode_cur = first ? bus.deci_mode : mode_q;
    k_cur    = first ? flog2(rate_in) : k_q;
    acc_new  = first ? AW'(bus.ad_data) : acc_q + AW'(bus.ad_data);
    last     = (cnt_q == n_cur - RW'(1));
    shifted  = acc_new >> k_cur;
    // Non-power-of-two windows can exceed full scale; clamp rather than wrap.
    avg      = (|shifted[AW-1:DW]) ? {DW{1'b1}} : shifted[DW-1:0];
`ifdef DECI_PEAK_EN
    max_new  = (first || bus.ad_data > max_q) ? bus.ad_data : max_q;
    min_new  = (first || bus.ad_data < min_q) ? bus.ad_data : min_q;
`endif

    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rate_d  = rate_q;
    mode_d  = mode_q;
    k_d     = k_q;
    valid_d = 1'b0;
    data_d  = data_q;
`ifdef DECI_PEAK_EN
    max_d   = max_q;
    min_d   = min_q;
    omax_d  = omax_q;
    omin_d  = omin_q;
`endif

    if (!bus.deci_en) begin
      cnt_d = '0;
      acc_d = '0;
`ifdef DECI_PEAK_EN
      max_d = '0;
      min_d = '0;
`endif
    end else if (bus.ad_valid) begin
      acc_d = acc_new;
`ifdef DECI_PEAK_EN
      max_d = max_new;
      min_d = min_new;
`endif
      if (first) begin
        rate_d = rate_in;
        mode_d = mode_cur;
        k_d    = k_cur;
      end
      if (last) begin
        cnt_d   = '0;
        valid_d = 1'b1;
`ifdef DECI_PEAK_EN
        if (mode_cur == MODE_AVG) begin
          data_d = avg;
          omax_d = max_new;
          omin_d = min_new;
        end else if (mode_cur == MODE_PEAK) begin
          data_d = max_new;
          omax_d = max_new;
          omin_d = min_new;
        end else begin
          data_d = bus.ad_data;
          omax_d = bus.ad_data;
          omin_d = bus.ad_data;
        end
`else
        data_d = (mode_cur == MODE_AVG) ? avg : bus.ad_data;
`endif
      end else begin
        cnt_d = cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      rate_q  <= RW'(1);
      mode_q  <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef DECI_PEAK_EN
      max_q   <= '0;
      min_q   <= '0;
      omax_q  <= '0;
      omin_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rate_q  <= rate_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef DECI_PEAK_EN
      max_q   <= max_d;
      min_q   <= min_d;
      omax_q  <= omax_d;
      omin_q  <= omin_d;
`endif
    end
  end

  assign bus.deci_valid = valid_q;
  assign bus.deci_data  = data_q;
`ifdef DECI_PEAK_EN
  assign bus.deci_max   = omax_q;
  assign bus.deci_min   = omin_q;
`else
  assign bus.deci_max   = data_q;
  assign bus.deci_min   = data_q;
`endif
endmodule

// File: tb/tb_deci_engine.sv
// Directed bench for deci_engine; expectations follow DECI_PEAK_EN when defined.
module tb_deci_engine;
  logic ad_clk = 1'b0;
  logic rst    = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  deci_engine_if #(.DW(8), .RW(10)) bus ();

  deci_engine #(.DW(8), .RW(10)) dut (
    .ad_clk (ad_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 ad_clk = ~ad_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Inputs change on the falling edge; outputs are read one falling edge later.
  task automatic feed(input logic en, input logic v, input logic [7:0] d);
    bus.deci_en  = en;
    bus.ad_valid = v;
    bus.ad_data  = d;
    @(posedge ad_clk);
    @(negedge ad_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.deci_rate = 10'd1;
    bus.deci_mode = 2'd0;
    feed(1'b1, 1'b1, 8'd77);
    feed(1'b1, 1'b1, 8'd78);
    n_total++;
    if (bus.deci_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.deci_valid); else n_pass++;
    n_total++;
    if (bus.deci_data !== 8'd0) $display("FAIL reset_data got %0d exp 0", bus.deci_data); else n_pass++;
    n_total++;
    if (bus.deci_max !== 8'd0) $display("FAIL reset_max got %0d exp 0", bus.deci_max); else n_pass++;
    n_total++;
    if (bus.deci_min !== 8'd0) $display("FAIL reset_min got %0d exp 0", bus.deci_min); else n_pass++;
    rst = 1'b0;
    feed(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_sample();
    logic ev;
    bus.deci_rate = 10'd4;
    bus.deci_mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      feed(1'b1, 1'b1, 8'(i));
      ev = (i % 4 == 3);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL sample_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
      if (ev) begin
        n_total++;
        if (bus.deci_data !== 8'(i) || bus.deci_max !== 8'(i) || bus.deci_min !== 8'(i))
          $display("FAIL sample_data[%0d] got %0d/%0d/%0d exp %0d", i, bus.deci_data, bus.deci_max, bus.deci_min, i);
        else n_pass++;
      end
    end
    feed(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_peak();
    logic [7:0] pat [5];
    logic [7:0] e_d, e_mx, e_mn;
    logic ev;
    pat[0] = 8'd10; pat[1] = 8'd200; pat[2] = 8'd3; pat[3] = 8'd50; pat[4] = 8'd60;
`ifdef DECI_PEAK_EN
    e_d = 8'd200; e_mx = 8'd200; e_mn = 8'd3;
`else
    e_d = 8'd60;  e_mx = 8'd60;  e_mn = 8'd60;
`endif
    bus.deci_rate = 10'd5;
    bus.deci_mode = 2'd1;
    for (int i = 0; i < 10; i++) begin
      feed(1'b1, 1'b1, pat[i % 5]);
      ev = (i % 5 == 4);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL peak_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
      if (ev) begin
        n_total++;
        if (bus.deci_data !== e_d || bus.deci_max !== e_mx || bus.deci_min !== e_mn)
          $display("FAIL peak_data[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", i,
                   bus.deci_data, bus.deci_max, bus.deci_min, e_d, e_mx, e_mn);
        else n_pass++;
      end
    end
    feed(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_average();
    logic [7:0] e_mx, e_mn;
    logic ev;
`ifdef DECI_PEAK_EN
    e_mx = 8'd7; e_mn = 8'd0;
`else
    e_mx = 8'd3; e_mn = 8'd3;
`endif
    bus.deci_rate = 10'd8;
    bus.deci_mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      feed(1'b1, 1'b1, 8'(i));
      ev = (i == 7);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL avg8_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
    end
    n_total++;
    if (bus.deci_data !== 8'd3 || bus.deci_max !== e_mx || bus.deci_min !== e_mn)
      $display("FAIL avg8_data got %0d/%0d/%0d exp 3/%0d/%0d", bus.deci_data, bus.deci_max, bus.deci_min, e_mx, e_mn);
    else n_pass++;
    bus.deci_rate = 10'd6;
    for (int i = 0; i < 6; i++) begin
      feed(1'b1, 1'b1, 8'd255);
      ev = (i == 5);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL avg6_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
    end
    n_total++;
    if (bus.deci_data !== 8'd255 || bus.deci_max !== 8'd255 || bus.deci_min !== 8'd255)
      $display("FAIL avg6_sat got %0d/%0d/%0d exp 255", bus.deci_data, bus.deci_max, bus.deci_min);
    else n_pass++;
    feed(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_rate_change();
    logic ev;
    bus.deci_mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      bus.deci_rate = (i < 2) ? 10'd4 : 10'd2;
      feed(1'b1, 1'b1, 8'(i));
      ev = (i == 3) || (i == 5) || (i == 7);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL rate_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
      if (ev) begin
        n_total++;
        if (bus.deci_data !== 8'(i)) $display("FAIL rate_data[%0d] got %0d exp %0d", i, bus.deci_data, i); else n_pass++;
      end
    end
    feed(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_gaps();
    logic v, ev;
    int   nv;
    nv = 0;
    bus.deci_rate = 10'd3;
    bus.deci_mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 0);
      feed(1'b1, v, 8'(i));
      if (v) nv++;
      ev = v && (nv % 3 == 0);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL gap_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
      if (ev) begin
        n_total++;
        if (bus.deci_data !== 8'(i)) $display("FAIL gap_data[%0d] got %0d exp %0d", i, bus.deci_data, i); else n_pass++;
      end
    end
  endtask

  task automatic test_enable_drop();
    logic ev;
    bus.deci_rate = 10'd4;
    bus.deci_mode = 2'd0;
    feed(1'b1, 1'b1, 8'd1);
    feed(1'b1, 1'b1, 8'd2);
    feed(1'b0, 1'b1, 8'd3);
    n_total++;
    if (bus.deci_valid !== 1'b0 || bus.deci_data !== 8'd10)
      $display("FAIL endrop_hold got %b/%0d exp 0/10", bus.deci_valid, bus.deci_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, 1'b1, 8'(10 + i));
      ev = (i == 3);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL endrop_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
    end
    n_total++;
    if (bus.deci_data !== 8'd13) $display("FAIL endrop_data got %0d exp 13", bus.deci_data); else n_pass++;
    feed(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_back_to_back();
    bus.deci_rate = 10'd0;
    bus.deci_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      feed(1'b1, 1'b1, 8'(5 + i));
      n_total++;
      if (bus.deci_valid !== 1'b1 || bus.deci_data !== 8'(5 + i))
        $display("FAIL b2b[%0d] got %b/%0d exp 1/%0d", i, bus.deci_valid, bus.deci_data, 5 + i);
      else n_pass++;
    end
    bus.deci_rate = 10'd1;
    bus.deci_mode = 2'd2;
    feed(1'b1, 1'b1, 8'd9);
    n_total++;
    if (bus.deci_valid !== 1'b1 || bus.deci_data !== 8'd9)
      $display("FAIL b2b_avg1 got %b/%0d exp 1/9", bus.deci_valid, bus.deci_data);
    else n_pass++;
    feed(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset_mid();
    logic ev;
    bus.deci_rate = 10'd4;
    bus.deci_mode = 2'd0;
    feed(1'b1, 1'b1, 8'd1);
    feed(1'b1, 1'b1, 8'd2);
    rst = 1'b1;
    feed(1'b1, 1'b1, 8'd3);
    rst = 1'b0;
    n_total++;
    if (bus.deci_valid !== 1'b0 || bus.deci_data !== 8'd0 || bus.deci_max !== 8'd0 || bus.deci_min !== 8'd0)
      $display("FAIL rstmid_out got %b/%0d/%0d/%0d exp 0/0/0/0", bus.deci_valid, bus.deci_data, bus.deci_max, bus.deci_min);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, 1'b1, 8'(20 + i));
      ev = (i == 3);
      n_total++;
      if (bus.deci_valid !== ev) $display("FAIL rstmid_valid[%0d] got %b exp %b", i, bus.deci_valid, ev); else n_pass++;
    end
    n_total++;
    if (bus.deci_data !== 8'd23) $display("FAIL rstmid_data got %0d exp 23", bus.deci_data); else n_pass++;
  endtask

  initial begin
    bus.deci_en   = 1'b0;
    bus.ad_valid  = 1'b0;
    bus.ad_data   = 8'd0;
    bus.deci_rate = 10'd1;
    bus.deci_mode = 2'd0;
    test_reset();
    test_sample();
    test_peak();
    test_average();
    test_rate_change();
    test_gaps();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
